// File: rtl/mcdf_reg_bank.sv
// Control/status register bank for the multi-channel data formatter: per-channel
// CTRL/STAT words, a low-margin interrupt with W1C status, and a registered cmd read port.
module mcdf_reg_bank #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rstn_i,
  input  logic [1:0]                                   cmd_i,
  input  logic [ADDR_W-1:0]                            cmd_addr_i,
  input  logic [31:0]                                  cmd_data_i,
  input  logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]     slv_margin_i,
  output logic [31:0]                                  cmd_data_o,
  output logic                                         cmd_rvalid_o,
  output logic                                         cmd_err_o,
  output logic [NUM_CH-1:0]                            slv_en_o,
  output logic [NUM_CH*2-1:0]                          slv_prio_o,
  output logic [NUM_CH*3-1:0]                          slv_pkglen_o,
  output logic                                         irq_o
);

  localparam int MW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = 6 + MW;

  logic [CW-1:0]     ctrl_q   [NUM_CH];
  logic [MW-1:0]     margin_q [NUM_CH];
  logic [MW-1:0]     min_q    [NUM_CH];
  logic [NUM_CH-1:0] below_q, int_stat, int_en;

  logic              rd, wr, err, do_wr, ctrl_blk, stat_blk, ist_hit, ien_hit;
  logic [3:0]        idx;
  logic [NUM_CH-1:0] ctrl_sel, stat_sel, below, w1c, int_stat_nxt;
  logic [31:0]       rdata;
  logic              unused_data;

  assign unused_data = ^cmd_data_i;

  // Address decode and read mux, evaluated on the cmd presented this cycle
  always_comb begin
    rd       = (cmd_i == 2'b01);
    wr       = (cmd_i == 2'b10);
    idx      = cmd_addr_i[5:2];
    ctrl_blk = (cmd_addr_i[1:0] == 2'b00) && (cmd_addr_i[ADDR_W-1:6] == '0);
    stat_blk = (cmd_addr_i[1:0] == 2'b00) && (cmd_addr_i[ADDR_W-1:6] == (ADDR_W-6)'(1));
    ist_hit  = (cmd_addr_i == ADDR_W'(8'h80));
    ien_hit  = (cmd_addr_i == ADDR_W'(8'h84));
    ctrl_sel = '0;
    stat_sel = '0;
    rdata    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (idx == 4'(n)) begin
        ctrl_sel[n] = ctrl_blk;
        stat_sel[n] = stat_blk;
      end
      if (ctrl_sel[n]) rdata = 32'(ctrl_q[n]);
      if (stat_sel[n]) rdata = (32'(min_q[n]) << 16) | 32'(margin_q[n]);
    end
    if (ist_hit) rdata = 32'(int_stat);
    if (ien_hit) rdata = 32'(int_en);
    err   = (rd || wr) &&
            (!(|ctrl_sel || |stat_sel || ist_hit || ien_hit) || (wr && |stat_sel));
    do_wr = wr && !err;
  end

  // Interrupt detection; a new rising below-threshold edge beats a same-cycle W1C
  always_comb begin
    for (int n = 0; n < NUM_CH; n++)
      below[n] = ctrl_q[n][0] && (margin_q[n] < ctrl_q[n][CW-1:6]);
    w1c          = (do_wr && ist_hit) ? cmd_data_i[NUM_CH-1:0] : '0;
    int_stat_nxt = (int_stat & ~w1c) | (below & ~below_q);
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      slv_en_o[n]          = ctrl_q[n][0];
      slv_prio_o[2*n +: 2] = ctrl_q[n][2:1];
      slv_pkglen_o[3*n +: 3] = ctrl_q[n][5:3];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < NUM_CH; n++) begin
        ctrl_q[n]   <= CW'(7);
        margin_q[n] <= MW'(FIFO_DEPTH);
        min_q[n]    <= MW'(FIFO_DEPTH);
      end
      below_q      <= '0;
      int_stat     <= '0;
      int_en       <= '0;
      irq_o        <= 1'b0;
      cmd_data_o   <= '0;
      cmd_rvalid_o <= 1'b0;
      cmd_err_o    <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        margin_q[n] <= slv_margin_i[n*MW +: MW];
        // STAT read clears the running minimum back to the current margin
        if (rd && stat_sel[n])
          min_q[n] <= margin_q[n];
        else if (margin_q[n] < min_q[n])
          min_q[n] <= margin_q[n];
        if (do_wr && ctrl_sel[n])
          ctrl_q[n] <= cmd_data_i[CW-1:0];
      end
      below_q  <= below;
      int_stat <= int_stat_nxt;
      if (do_wr && ien_hit)
        int_en <= cmd_data_i[NUM_CH-1:0];
      irq_o        <= |(int_stat & int_en);
      cmd_data_o   <= rd ? rdata : '0;
      cmd_rvalid_o <= rd;
      cmd_err_o    <= err;
    end
  end

endmodule

// File: tb/tb_mcdf_reg_bank.sv
// Directed bench for mcdf_reg_bank at NUM_CH=3, FIFO_DEPTH=64.
module tb_mcdf_reg_bank;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  cmd;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [6:0]  m0, m1, m2;
  logic [20:0] slv_margin;
  logic [31:0] rdata;
  logic        rvalid, err, irq;
  logic [2:0]  en;
  logic [5:0]  prio;
  logic [8:0]  pkglen;

  int n_checks = 0;
  int n_fail   = 0;

  assign slv_margin = {m2, m1, m0};

  always #5 clk = ~clk;

  mcdf_reg_bank #(.NUM_CH(3), .FIFO_DEPTH(64), .ADDR_W(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .cmd_i(cmd), .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data), .slv_margin_i(slv_margin), .cmd_data_o(rdata),
    .cmd_rvalid_o(rvalid), .cmd_err_o(err), .slv_en_o(en), .slv_prio_o(prio),
    .slv_pkglen_o(pkglen), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One command cycle; returns at the falling edge where its results are visible
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    cmd = op; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    cmd = 2'b00; cmd_addr = '0; cmd_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; cmd = 2'b00; cmd_addr = '0; cmd_data = '0;
    m0 = 7'd64; m1 = 7'd64; m2 = 7'd64;
    idle(3);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_irq",    32'(irq),    32'd0);
    check("rst_data",   rdata,       32'd0);
    check("rst_en",     32'(en),     32'h7);
    check("rst_prio",   32'(prio),   32'h3f);
    check("rst_pkglen", 32'(pkglen), 32'h0);
    rstn = 1'b1;

    for (int n = 0; n < 3; n++) begin
      do_cmd(RD, 8'(4*n), '0);
      check($sformatf("ctrl%0d_rd", n), rdata, 32'h7);
      check($sformatf("ctrl%0d_rv", n), 32'(rvalid), 32'd1);
      do_cmd(RD, 8'(8'h40 + 4*n), '0);
      check($sformatf("stat%0d_rd", n), rdata, 32'h0040_0040);
      check($sformatf("stat%0d_rv", n), 32'(rvalid), 32'd1);
    end
    idle(1);
    check("rvalid_drop", 32'(rvalid), 32'd0);

    // Write CTRL1, then read it back in the very next cycle
    @(negedge clk); cmd = WR; cmd_addr = 8'h04; cmd_data = 32'h0000_029D;
    @(negedge clk); cmd = RD; cmd_data = '0;
    check("wr_en",     32'(en),     32'h7);
    check("wr_prio",   32'(prio),   32'h3b);
    check("wr_pkglen", 32'(pkglen), 32'h018);
    check("wr_err",    32'(err),    32'd0);
    @(negedge clk); cmd = 2'b00; cmd_addr = '0;
    check("ctrl1_rd_after_wr", rdata, 32'h29D);
    do_cmd(WR, 8'h04, 32'hFFFF_E29D);
    do_cmd(RD, 8'h04, '0);
    check("ctrl1_upper_zero", rdata, 32'h29D);

    // Illegal accesses
    do_cmd(WR, 8'h44, 32'hFFFF_FFFF);
    check("err_wr_stat", 32'(err), 32'd1);
    do_cmd(WR, 8'h0C, 32'h0);
    check("err_wr_ch3", 32'(err), 32'd1);
    do_cmd(WR, 8'h02, 32'h0);
    check("err_wr_misal", 32'(err), 32'd1);
    check("err_en_kept", 32'(en), 32'h7);
    do_cmd(RD, 8'h0C, '0);
    check("err_rd_data", rdata, 32'd0);
    check("err_rd_rv",   32'(rvalid), 32'd1);
    check("err_rd_err",  32'(err), 32'd1);
    do_cmd(RD, 8'h00, '0);
    check("err_ctrl0_kept", rdata, 32'h7);
    do_cmd(RD, 8'h44, '0);
    check("err_stat1_kept", rdata, 32'h0040_0040);

    // Low-margin interrupt on channel 0, thr=16
    do_cmd(WR, 8'h00, 32'h0000_0407);
    do_cmd(WR, 8'h84, 32'h1);
    m0 = 7'd15;
    idle(1); check("irq_e1", 32'(irq), 32'd0);
    idle(1); check("irq_e2", 32'(irq), 32'd0);
    idle(1); check("irq_e3", 32'(irq), 32'd1);
    do_cmd(RD, 8'h80, '0);
    check("int_stat_set", rdata, 32'h1);
    do_cmd(WR, 8'h80, 32'h1);
    idle(1);
    check("irq_w1c", 32'(irq), 32'd0);
    idle(4);
    check("irq_no_retrig", 32'(irq), 32'd0);
    m0 = 7'd16;
    idle(4);
    check("irq_at_thr", 32'(irq), 32'd0);
    m0 = 7'd15;
    idle(3);
    check("irq_retrig", 32'(irq), 32'd1);

    // Minimum tracking and clear-on-read on channel 2
    m2 = 7'd20; idle(2);
    m2 = 7'd40; idle(3);
    do_cmd(RD, 8'h48, '0);
    check("stat2_min", rdata, 32'h0014_0028);
    do_cmd(RD, 8'h48, '0);
    check("stat2_clr", rdata, 32'h0028_0028);

    // W1C colliding with a fresh set: set wins
    do_cmd(WR, 8'h80, 32'h1);
    m0 = 7'd16; idle(3);
    m0 = 7'd15;
    @(negedge clk); cmd = WR; cmd_addr = 8'h80; cmd_data = 32'h1;
    @(negedge clk); cmd = 2'b00; cmd_addr = '0; cmd_data = '0;
    do_cmd(RD, 8'h80, '0);
    check("w1c_set_wins", rdata, 32'h1);
    check("irq_before_rst", 32'(irq), 32'd1);

    // Reset in the middle of a read result
    @(negedge clk); cmd = RD; cmd_addr = 8'h00;
    @(posedge clk); #1;
    check("rv_before_rst", 32'(rvalid), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_irq",    32'(irq),    32'd0);
    check("rst_mid_data",   rdata,       32'd0);
    check("rst_mid_prio",   32'(prio),   32'h3f);
    cmd = 2'b00;
    idle(2);
    rstn = 1'b1;
    do_cmd(RD, 8'h80, '0);
    check("rst_int_stat", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
